// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU with valid/ready handshake and iterative shifts
//
// Purpose: WIDTH-generic ALU between register read and writeback. Single-cycle ops
//   complete on the accept edge. SLL/SLR with a non-zero amount iterate SHIFT_STEP
//   bits per cycle. The result and flags are registered and are announced by a
//   one-cycle valid_o pulse.
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   valid_i/ready_o  request handshake; a request is taken when both are high at the edge
//   op_i             opcode
//   data1_i/data2_i  operands A/B; shifts take the amount from data2_i[$clog2(WIDTH)-1:0]
//   valid_o          one-cycle pulse when data_o and the flags hold a new result
//   data_o           registered result
//   zf_o/sf_o/cf_o/of_o  zero/sign/carry/overflow flags, registered
module alu_mc #(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             zf_o,
   output logic             sf_o,
   output logic             cf_o,
   output logic             of_o
);

   localparam logic [3:0] OP_OR  = 4'd0;
   localparam logic [3:0] OP_AND = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_SLL = 4'd3;
   localparam logic [3:0] OP_SLR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_NEG = 4'd6;
   localparam logic [3:0] OP_ADD = 4'd7;
   localparam logic [3:0] OP_SUB = 4'd8;
   localparam logic [3:0] OP_CMP = 4'd9;
   localparam logic [3:0] OP_MOV = 4'd10;

   localparam int NW  = $clog2(WIDTH);
   // One extra bit so that SHIFT_STEP == WIDTH is representable.
   localparam int CW  = NW + 1;
   localparam int MSB = WIDTH - 1;
   localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             dir_right;

   logic          accept;
   logic [NW-1:0] amount;
   logic          is_shift;
   logic          start_shift;

   assign accept      = valid_i & ready_o;
   assign amount      = data2_i[NW-1:0];
   assign is_shift    = (op_i == OP_SLL) || (op_i == OP_SLR);
   assign start_shift = accept && is_shift && (amount != '0);

   // Iterative shifter: shift through one extra bit so the last bit shifted
   // out lands at a fixed position (carry) without a variable index.
   logic [CW-1:0]    step;
   logic             last_step;
   logic [WIDTH:0]   sll_ext, srl_ext;
   logic [WIDTH-1:0] sh_res;
   logic             sh_cf;

   assign step      = (cnt < STEP_C) ? cnt : STEP_C;
   assign last_step = (cnt == step);
   assign sll_ext   = {1'b0, acc} << step;
   assign srl_ext   = {acc, 1'b0} >> step;
   assign sh_res    = dir_right ? srl_ext[WIDTH:1] : sll_ext[WIDTH-1:0];
   assign sh_cf     = dir_right ? srl_ext[0] : sll_ext[WIDTH];

   // Single-cycle result; the upd_* enables mark which flags this op writes.
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cf, alu_of;
   logic             upd_zs, upd_cf, upd_of;

   assign sum  = {1'b0, data1_i} + {1'b0, data2_i};
   assign diff = {1'b0, data1_i} - {1'b0, data2_i};

   always_comb begin
      alu_res = '0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      upd_zs  = 1'b0;
      upd_cf  = 1'b0;
      upd_of  = 1'b0;
      case (op_i)
         OP_OR, OP_AND, OP_XOR: begin
            alu_res = (op_i == OP_OR)  ? (data1_i | data2_i) :
                      (op_i == OP_AND) ? (data1_i & data2_i) : (data1_i ^ data2_i);
            upd_zs  = 1'b1;
            upd_cf  = 1'b1;
            upd_of  = 1'b1;
         end
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_cf  = sum[WIDTH];
            alu_of  = (data1_i[MSB] == data2_i[MSB]) && (alu_res[MSB] != data1_i[MSB]);
            upd_zs  = 1'b1;
            upd_cf  = 1'b1;
            upd_of  = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            alu_res = diff[WIDTH-1:0];
            alu_cf  = diff[WIDTH];
            alu_of  = (data1_i[MSB] != data2_i[MSB]) && (alu_res[MSB] != data1_i[MSB]);
            upd_zs  = 1'b1;
            upd_cf  = 1'b1;
            upd_of  = 1'b1;
         end
         // Only reached with a zero amount: pass A through, carry untouched.
         OP_SLL, OP_SLR: begin
            alu_res = data1_i;
            upd_zs  = 1'b1;
            upd_of  = 1'b1;
         end
         OP_NOT: alu_res = ~data1_i;
         OP_NEG: alu_res = '0 - data1_i;
         OP_MOV: alu_res = data2_i;
         default: alu_res = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (accept) state_nxt = start_shift ? SHIFT : DONE;
            else        state_nxt = IDLE;
         end
         SHIFT:   state_nxt = last_step ? DONE : SHIFT;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_o = (state != SHIFT);
      valid_o = (state == DONE);
   end

   // Datapath: shift working registers, result and flags
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc       <= '0;
         cnt       <= '0;
         dir_right <= 1'b0;
         data_o    <= '0;
         zf_o      <= 1'b0;
         sf_o      <= 1'b0;
         cf_o      <= 1'b0;
         of_o      <= 1'b0;
      end else if (state == SHIFT) begin
         acc <= sh_res;
         cnt <= cnt - step;
         if (last_step) begin
            data_o <= sh_res;
            zf_o   <= (sh_res == '0);
            sf_o   <= sh_res[MSB];
            cf_o   <= sh_cf;
            of_o   <= 1'b0;
         end
      end else if (accept) begin
         if (start_shift) begin
            acc       <= data1_i;
            cnt       <= {1'b0, amount};
            dir_right <= (op_i == OP_SLR);
         end else begin
            data_o <= alu_res;
            if (upd_zs) begin
               zf_o <= (alu_res == '0);
               sf_o <= alu_res[MSB];
            end
            if (upd_cf) cf_o <= alu_cf;
            if (upd_of) of_o <= alu_of;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc (SHIFT_STEP 1 and 4 instances)
module tb_alu_mc;

   localparam logic [3:0] OP_OR  = 4'd0;
   localparam logic [3:0] OP_AND = 4'd1;
   localparam logic [3:0] OP_SLL = 4'd3;
   localparam logic [3:0] OP_SLR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_ADD = 4'd7;
   localparam logic [3:0] OP_SUB = 4'd8;
   localparam logic [3:0] OP_CMP = 4'd9;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  op  = 4'd0;
   logic [15:0] a   = 16'd0;
   logic [15:0] b   = 16'd0;
   logic        v1  = 1'b0;
   logic        v4  = 1'b0;

   logic        rdy1, val1, zf1, sf1, cf1, of1;
   logic [15:0] d1;
   logic        rdy4, val4, zf4, sf4, cf4, of4;
   logic [15:0] d4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(16), .SHIFT_STEP(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(rdy1), .op_i(op),
      .data1_i(a), .data2_i(b), .valid_o(val1), .data_o(d1),
      .zf_o(zf1), .sf_o(sf1), .cf_o(cf1), .of_o(of1));

   alu_mc #(.WIDTH(16), .SHIFT_STEP(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .valid_i(v4), .ready_o(rdy4), .op_i(op),
      .data1_i(a), .data2_i(b), .valid_o(val4), .data_o(d4),
      .zf_o(zf4), .sf_o(sf4), .cf_o(cf4), .of_o(of4));

   // Issue one request to the selected instance and measure cycles from the
   // accept edge to the first negedge that sees valid_o; also reports whether
   // ready_o was seen high while waiting.
   task automatic run_op(input bit sel4, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y, output int lat, output bit rdy_seen);
      @(negedge clk);
      op = o; a = x; b = y;
      if (sel4) v4 = 1'b1; else v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0; v4 = 1'b0;
      a = 16'h5A5A; b = 16'h0003; op = OP_ADD;
      lat = 1;
      rdy_seen = 1'b0;
      while (((sel4 ? val4 : val1) == 1'b0) && lat < 40) begin
         if (sel4 ? rdy4 : rdy1) rdy_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      int lat;
      bit rs;
      bit saw_valid;
      #1;
      checks++; if ({d1, zf1, sf1, cf1, of1} !== 20'd0) begin errors++; $display("FAIL reset_outputs: got %h/%b%b%b%b want 0", d1, zf1, sf1, cf1, of1); end
      checks++; if ({rdy1, val1, rdy4, val4} !== 4'b1010) begin errors++; $display("FAIL reset_handshake: got %b want 1010", {rdy1, val1, rdy4, val4}); end
      @(negedge clk);
      rst = 1'b1;
      run_op(1'b0, OP_ADD, 16'd3, 16'd4, lat, rs);
      checks++; if (d1 !== 16'd7) begin errors++; $display("FAIL reset_pre_add: got %h want 0007", d1); end
      @(negedge clk);
      op = OP_SLL; a = 16'hFFFF; b = 16'd15; v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_mid_shift_busy: ready got %b want 0", rdy1); end
      rst = 1'b0;
      #1;
      checks++; if ({d1, zf1, sf1, cf1, of1} !== 20'd0) begin errors++; $display("FAIL reset_async_outputs: got %h/%b%b%b%b want 0", d1, zf1, sf1, cf1, of1); end
      checks++; if ({rdy1, val1} !== 2'b10) begin errors++; $display("FAIL reset_async_handshake: got %b want 10", {rdy1, val1}); end
      @(negedge clk);
      rst = 1'b1;
      saw_valid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (val1) saw_valid = 1'b1;
      end
      checks++; if (saw_valid !== 1'b0 || d1 !== 16'd0) begin errors++; $display("FAIL reset_discard: valid seen %b data %h want 0/0000", saw_valid, d1); end
   endtask

   task automatic test_add;
      int lat;
      bit rs;
      run_op(1'b0, OP_ADD, 16'hFFFF, 16'h0001, lat, rs);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
      checks++; if (d1 !== 16'h0000) begin errors++; $display("FAIL add_data: got %h want 0000", d1); end
      checks++; if ({zf1, sf1, cf1, of1} !== 4'b1010) begin errors++; $display("FAIL add_flags: zscf got %b want 1010", {zf1, sf1, cf1, of1}); end
      @(negedge clk);
      checks++; if (val1 !== 1'b0 || d1 !== 16'h0000) begin errors++; $display("FAIL add_pulse_hold: valid %b data %h want 0/0000", val1, d1); end
   endtask

   task automatic test_sub;
      int lat;
      bit rs;
      run_op(1'b0, OP_SUB, 16'h8000, 16'h0001, lat, rs);
      checks++; if (d1 !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_data: got %h want 7fff", d1); end
      checks++; if ({zf1, sf1, cf1, of1} !== 4'b0001) begin errors++; $display("FAIL sub_ovf_flags: zscf got %b want 0001", {zf1, sf1, cf1, of1}); end
      run_op(1'b0, OP_SUB, 16'h0000, 16'h0001, lat, rs);
      checks++; if (d1 !== 16'hFFFF) begin errors++; $display("FAIL sub_borrow_data: got %h want ffff", d1); end
      checks++; if ({zf1, sf1, cf1, of1} !== 4'b0110) begin errors++; $display("FAIL sub_borrow_flags: zscf got %b want 0110", {zf1, sf1, cf1, of1}); end
   endtask

   task automatic test_shift_step1;
      int lat;
      bit rs;
      run_op(1'b0, OP_SLL, 16'h8001, 16'd1, lat, rs);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sll1_latency: got %0d want 2", lat); end
      checks++; if (d1 !== 16'h0002 || cf1 !== 1'b1) begin errors++; $display("FAIL sll1_result: got %h cf %b want 0002 cf 1", d1, cf1); end
      run_op(1'b0, OP_SLR, 16'h8000, 16'd15, lat, rs);
      checks++; if (lat !== 16) begin errors++; $display("FAIL slr15_latency: got %0d want 16", lat); end
      checks++; if (d1 !== 16'h0001 || cf1 !== 1'b0) begin errors++; $display("FAIL slr15_result: got %h cf %b want 0001 cf 0", d1, cf1); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL slr15_busy: ready seen %b want 0", rs); end
   endtask

   task automatic test_shift_step4;
      int lat;
      bit rs;
      run_op(1'b1, OP_SLR, 16'h00F0, 16'd5, lat, rs);
      checks++; if (lat !== 3) begin errors++; $display("FAIL slr5_step4_latency: got %0d want 3", lat); end
      checks++; if (d4 !== 16'h0007 || cf4 !== 1'b1) begin errors++; $display("FAIL slr5_step4_result: got %h cf %b want 0007 cf 1", d4, cf4); end
      run_op(1'b1, OP_SLL, 16'h1234, 16'd0, lat, rs);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sll0_latency: got %0d want 1", lat); end
      checks++; if (d4 !== 16'h1234 || cf4 !== 1'b1) begin errors++; $display("FAIL sll0_result: got %h cf %b want 1234 cf 1", d4, cf4); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      op = OP_OR; a = 16'd15; b = 16'd25; v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (val1 !== 1'b1 || d1 !== 16'd31 || rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_or: valid %b ready %b data %0d want 1/1/31", val1, rdy1, d1); end
      op = OP_AND;
      @(posedge clk);
      @(negedge clk);
      checks++; if (val1 !== 1'b1 || d1 !== 16'd9) begin errors++; $display("FAIL b2b_and: valid %b data %0d want 1/9", val1, d1); end
      op = OP_CMP; a = 16'd5; b = 16'd7;
      @(posedge clk);
      @(negedge clk);
      checks++; if (d1 !== 16'hFFFE || {zf1, sf1, cf1, of1} !== 4'b0110) begin errors++; $display("FAIL b2b_cmp: data %h zscf %b want fffe 0110", d1, {zf1, sf1, cf1, of1}); end
      op = OP_NOT;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      checks++; if (val1 !== 1'b1 || d1 !== 16'hFFFA || {zf1, sf1, cf1, of1} !== 4'b0110) begin errors++; $display("FAIL b2b_not_flags: valid %b data %h zscf %b want 1 fffa 0110", val1, d1, {zf1, sf1, cf1, of1}); end
      @(negedge clk);
      checks++; if (val1 !== 1'b0) begin errors++; $display("FAIL b2b_idle: valid got %b want 0", val1); end
   endtask

   task automatic test_undefined;
      int lat;
      bit rs;
      run_op(1'b0, 4'd15, 16'hABCD, 16'h1111, lat, rs);
      checks++; if (lat !== 1 || d1 !== 16'h0000 || {zf1, sf1, cf1, of1} !== 4'b0110) begin errors++; $display("FAIL undef_op: lat %0d data %h zscf %b want 1 0000 0110", lat, d1, {zf1, sf1, cf1, of1}); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_shift_step1();
      test_shift_step4();
      test_back_to_back();
      test_undefined();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
